wb_byte_master: RTL and testbench
=================================

# wb_byte_master

Byte-stream command decoder and Wishbone master that drives the network core's 8-bit Wishbone slave port (CYC/STB/WE/ADDR/WDATA/SEL in, STALL/ACK/RDATA/ERR out). Sits directly upstream of the network top, between a UART RX/TX pair and the register pool. It turns 'W'/'R' command frames into single pipelined-Wishbone transactions and returns one- or two-byte status/data responses. It lets weights, biases, input grid and CORE_CTRL be loaded from a host.

## Interface
- TIMEOUT_CYCLES, 1024: max cycles from STB issue to ACK/ERR before abort; must be ≥2.
- CNT_W, 16: width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

- CLK  in  1  system clock; all logic on rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- RX_DATA  in  8  command byte from UART RX.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  block accepts RX_DATA this cycle.
- TX_DATA  out  8  response byte to UART TX.
- TX_VALID  out  1  TX_DATA valid; held with stable data until TX_READY.
- TX_READY  in  1  UART TX accepts byte.
- CYC  out  1  Wishbone cycle.
- STB  out  1  Wishbone strobe.
- WE  out  1  1 = write.
- ADDR  out  32  byte address (register pool offset).
- WDATA  out  8  write data.
- SEL  out  1  byte select; equals STB.
- STALL  in  1  slave stall.
- ACK  in  1  slave acknowledge.
- RDATA  in  8  read data, valid with ACK.
- ERR  in  1  slave error.
- BUSY  out  1  high in any state except IDLE.

## Operation
- Frames (bytes, address MSB first): write = 0x57, A3, A2, A1, A0, D; read = 0x52, A3, A2, A1, A0.
- Responses: write OK = 0x06; read OK = 0x06 then RDATA byte; ERR = 0x15; timeout = 0x54; unknown command byte = 0x3F.
- States: IDLE, ADDR, DATA, REQ, WAIT, RSP_STAT, RSP_DATA.
- IDLE: RX_READY=1. On RX handshake: 0x57 → ADDR (WE latch 1); 0x52 → ADDR (WE latch 0); other → RSP_STAT with 0x3F.
- ADDR: RX_READY=1; shift each accepted byte into ADDR register; after 4th byte → DATA if write, else REQ.
- DATA: RX_READY=1; accepted byte → WDATA; → REQ.
- REQ: CYC=STB=1, timeout counter counts. If STALL=0 the request is accepted this cycle → WAIT (STB drops next cycle). ACK/ERR in the same cycle as acceptance is handled as in WAIT.
- WAIT: CYC=1, STB=0. ACK → latch RDATA, status 0x06; ERR → status 0x15 (ERR wins if both); → RSP_STAT. CYC drops the cycle after ACK/ERR.
- Timeout: counter cleared on entry to REQ, increments every REQ/WAIT cycle; on reaching TIMEOUT_CYCLES with no ACK/ERR, CYC/STB drop next cycle, status 0x54 → RSP_STAT. Late ACK/ERR after abort ignored.
- RSP_STAT: TX_VALID=1, TX_DATA=status. On TX handshake → RSP_DATA if read and status 0x06, else IDLE.
- RSP_DATA: TX_VALID=1, TX_DATA=latched RDATA; on handshake → IDLE.
- RX_READY=0 in REQ, WAIT, RSP_*; bytes arriving then are back-pressured, never dropped.
- Exactly one bus transaction per frame; no pipelining of multiple requests.

## Timing
- Reset (RSTN=0 at a rising edge): state IDLE; CYC, STB, WE, SEL, TX_VALID, BUSY = 0; ADDR=0, WDATA=0, TX_DATA=0; RX_READY=1 from first cycle after reset release. Reset mid-frame or mid-transaction aborts immediately: CYC/STB low the cycle after the reset edge, partial frame discarded, no response.
- All outputs registered.
- Last frame byte accepted at edge N → CYC=STB=1 from N+1.
- STALL=0 at edge M (in REQ) → STB=0 from M+1; ACK at edge K → CYC=0 and TX_VALID=1 from K+1.
- Zero-wait slave (STALL=0, ACK in the first REQ cycle): response byte valid 2 cycles after last frame byte.
- Timeout abort: CYC low exactly TIMEOUT_CYCLES+1 cycles after CYC rose.
- TX_DATA stable while TX_VALID=1 and TX_READY=0.

## Test plan
- Write: RX 57 00 00 00 10 20, slave ACK after 0 stall → one cycle WE=1, ADDR=0x10, WDATA=0x20, SEL=1; TX 0x06; CYC high 2 cycles.
- Read with stall: RX 52 00 00 00 24, STALL=1 for 3 cycles then ACK with RDATA=0xE0 → STB high 4 cycles, TX 0x06 then 0xE0.
- Error: write to 0xFFFF0000, slave ERR → TX single 0x15; read with ERR → 0x15 only, no data byte.
- Timeout: TIMEOUT_CYCLES=8, slave never responds → CYC falls 9 cycles after rising, TX 0x54, subsequent late ACK ignored, next frame works.
- Back-pressure/unknown: RX 0x41 → TX 0x3F; hold TX_READY=0 for 5 cycles → TX_VALID and TX_DATA stable, RX_READY=0 throughout.
- Reset mid-frame: RX 57 00 00, assert RSTN=0 one cycle, then full valid write frame → exactly one transaction, one 0x06 response.

Source files
------------

// File: rtl/wb_byte_master.sv
// Byte-stream command decoder driving a single-beat pipelined Wishbone master.
// 'W'/'R' frames from the UART become one bus transaction each, answered with status/data bytes.
module wb_byte_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [7:0]  o_wdata,
  output logic        o_sel,
  input  logic        i_stall,
  input  logic        i_ack,
  input  logic [7:0]  i_rdata,
  input  logic        i_err,
  output logic        o_busy
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] ST_OK     = 8'h06;
  localparam logic [7:0] ST_ERR    = 8'h15;
  localparam logic [7:0] ST_TMO    = 8'h54;
  localparam logic [7:0] ST_UNK    = 8'h3F;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RSP_STAT, S_RSP_DATA
  } state_t;

  state_t           r_state;
  logic [31:0]      r_addr;
  logic [7:0]       r_wdata;
  logic             r_we;
  logic [7:0]       r_stat;
  logic [7:0]       r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_bcnt;
  logic             r_cyc;
  logic             r_stb;
  logic             r_rx_ready;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic             r_busy;

  state_t           w_next;
  logic [31:0]      w_addr;
  logic [7:0]       w_wdata;
  logic             w_we;
  logic [7:0]       w_stat;
  logic [7:0]       w_rdata;
  logic [CNT_W-1:0] w_cnt;
  logic [1:0]       w_bcnt;
  logic             w_rx_hs;
  logic             w_tx_hs;

  assign w_rx_hs = i_rx_valid && r_rx_ready;
  assign w_tx_hs = r_tx_valid && i_tx_ready;

  always_comb begin
    w_next  = r_state;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_we    = r_we;
    w_stat  = r_stat;
    w_rdata = r_rdata;
    w_cnt   = r_cnt;
    w_bcnt  = r_bcnt;
    case (r_state)
      S_IDLE: begin
        if (w_rx_hs) begin
          w_bcnt = 2'd0;
          if (i_rx_data == CMD_WRITE) begin
            w_we   = 1'b1;
            w_next = S_ADDR;
          end else if (i_rx_data == CMD_READ) begin
            w_we   = 1'b0;
            w_next = S_ADDR;
          end else begin
            w_stat = ST_UNK;
            w_next = S_RSP_STAT;
          end
        end
      end
      S_ADDR: begin
        if (w_rx_hs) begin
          w_addr = {r_addr[23:0], i_rx_data};
          w_bcnt = r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            w_cnt  = '0;
            w_next = r_we ? S_DATA : S_REQ;
          end
        end
      end
      S_DATA: begin
        if (w_rx_hs) begin
          w_wdata = i_rx_data;
          w_cnt   = '0;
          w_next  = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        // A response only counts once the request has been accepted (no stall in REQ).
        w_cnt = r_cnt + 1'b1;
        if ((r_state == S_WAIT || !i_stall) && i_err) begin
          w_stat = ST_ERR;
          w_next = S_RSP_STAT;
        end else if ((r_state == S_WAIT || !i_stall) && i_ack) begin
          w_stat  = ST_OK;
          w_rdata = i_rdata;
          w_next  = S_RSP_STAT;
        end else if (r_cnt == TO_LIM) begin
          w_stat = ST_TMO;
          w_next = S_RSP_STAT;
        end else if (r_state == S_REQ && !i_stall) begin
          w_next = S_WAIT;
        end
      end
      S_RSP_STAT: begin
        if (w_tx_hs) begin
          w_next = (!r_we && r_stat == ST_OK) ? S_RSP_DATA : S_IDLE;
        end
      end
      S_RSP_DATA: begin
        if (w_tx_hs) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Every output is decoded from the next state so it leaves a flop.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_stat     <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
      r_bcnt     <= '0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_rx_ready <= 1'b1;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_we       <= w_we;
      r_stat     <= w_stat;
      r_rdata    <= w_rdata;
      r_cnt      <= w_cnt;
      r_bcnt     <= w_bcnt;
      r_cyc      <= (w_next == S_REQ) || (w_next == S_WAIT);
      r_stb      <= (w_next == S_REQ);
      r_rx_ready <= (w_next == S_IDLE) || (w_next == S_ADDR) || (w_next == S_DATA);
      r_tx_valid <= (w_next == S_RSP_STAT) || (w_next == S_RSP_DATA);
      r_busy     <= (w_next != S_IDLE);
      if (w_next == S_RSP_STAT) begin
        r_tx_data <= w_stat;
      end else if (w_next == S_RSP_DATA) begin
        r_tx_data <= w_rdata;
      end
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_cyc      = r_cyc;
  assign o_stb      = r_stb;
  assign o_sel      = r_stb;
  assign o_we       = r_we;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed self-checking bench for wb_byte_master with a hand-driven Wishbone slave.
module tb_wb_byte_master;

   logic        clock;
   logic        rstn;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        rxReady;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] addr;
   logic [7:0]  wdata;
   logic        sel;
   logic        stall;
   logic        ack;
   logic [7:0]  rdata;
   logic        err;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   int hiCount;

   wb_byte_master #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
      .i_clk(clock), .i_rstn(rstn),
      .i_rx_data(rxData), .i_rx_valid(rxValid), .o_rx_ready(rxReady),
      .o_tx_data(txData), .o_tx_valid(txValid), .i_tx_ready(txReady),
      .o_cyc(cyc), .o_stb(stb), .o_we(we), .o_addr(addr), .o_wdata(wdata), .o_sel(sel),
      .i_stall(stall), .i_ack(ack), .i_rdata(rdata), .i_err(err),
      .o_busy(busy)
   );

   // Free-running clock; the bench drives and samples on the falling edge.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // One comparison: counts the vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Offer one RX byte and return at the falling edge after it was accepted.
   task automatic applyStimulus(input logic [7:0] b);
      int n;
      rxData  = b;
      rxValid = 1'b1;
      n = 0;
      while (!rxReady && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!rxReady) checkOutput("rx_ready_wait", {31'd0, rxReady}, 32'd1);
      @(negedge clock);
      rxValid = 1'b0;
   endtask

   // Accept one TX byte and compare it with the expected response.
   task automatic expectResponse(input string tag, input logic [7:0] expected);
      int n;
      txReady = 1'b1;
      n = 0;
      while (!txValid && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!txValid) checkOutput({tag, "_wait"}, {31'd0, txValid}, 32'd1);
      checkOutput(tag, {24'd0, txData}, {24'd0, expected});
      @(negedge clock);
      txReady = 1'b0;
   endtask

   // Linear sequence of directed steps.
   initial begin
      rstn = 1'b0; rxData = 8'h00; rxValid = 1'b0; txReady = 1'b0;
      stall = 1'b0; ack = 1'b0; rdata = 8'h00; err = 1'b0;
      repeat (3) @(negedge clock);

      checkOutput("rst_cyc", {31'd0, cyc}, 32'd0);
      checkOutput("rst_stb", {31'd0, stb}, 32'd0);
      checkOutput("rst_we", {31'd0, we}, 32'd0);
      checkOutput("rst_sel", {31'd0, sel}, 32'd0);
      checkOutput("rst_txvalid", {31'd0, txValid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_addr", addr, 32'd0);
      checkOutput("rst_wdata", {24'd0, wdata}, 32'd0);
      checkOutput("rst_txdata", {24'd0, txData}, 32'd0);
      rstn = 1'b1;
      @(negedge clock);
      checkOutput("rst_rxready", {31'd0, rxReady}, 32'd1);

      // Write 0x20 to 0x10, slave acks one cycle after acceptance.
      applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h20);
      checkOutput("wr_cyc", {31'd0, cyc}, 32'd1);
      checkOutput("wr_stb", {31'd0, stb}, 32'd1);
      checkOutput("wr_sel", {31'd0, sel}, 32'd1);
      checkOutput("wr_we", {31'd0, we}, 32'd1);
      checkOutput("wr_addr", addr, 32'h10);
      checkOutput("wr_wdata", {24'd0, wdata}, 32'h20);
      checkOutput("wr_rxready_busy", {31'd0, rxReady}, 32'd0);
      @(negedge clock);
      checkOutput("wr_stb_drop", {31'd0, stb}, 32'd0);
      checkOutput("wr_cyc_wait", {31'd0, cyc}, 32'd1);
      ack = 1'b1;
      @(negedge clock);
      ack = 1'b0;
      checkOutput("wr_cyc_drop", {31'd0, cyc}, 32'd0);
      checkOutput("wr_txvalid", {31'd0, txValid}, 32'd1);
      expectResponse("wr_resp", 8'h06);
      checkOutput("wr_idle_txvalid", {31'd0, txValid}, 32'd0);
      checkOutput("wr_idle_busy", {31'd0, busy}, 32'd0);

      // Read from 0x24 with three stalled request cycles, then RDATA 0xE0.
      stall = 1'b1;
      applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h24);
      checkOutput("rd_addr", addr, 32'h24);
      checkOutput("rd_we", {31'd0, we}, 32'd0);
      hiCount = 0;
      for (int i = 0; i < 6; i++) begin
         if (stb) hiCount++;
         if (i == 3) stall = 1'b0;
         if (i == 4) begin ack = 1'b1; rdata = 8'hE0; end
         if (i == 5) begin
            ack = 1'b0;
            checkOutput("rd_cyc_drop", {31'd0, cyc}, 32'd0);
            checkOutput("rd_txvalid", {31'd0, txValid}, 32'd1);
         end
         @(negedge clock);
      end
      checkOutput("rd_stb_cycles", hiCount, 32'd4);
      expectResponse("rd_status", 8'h06);
      expectResponse("rd_data", 8'hE0);
      checkOutput("rd_idle_busy", {31'd0, busy}, 32'd0);

      // Zero-wait read: ACK in the same cycle the request is accepted.
      applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h30);
      ack = 1'b1; rdata = 8'h5A;
      @(negedge clock);
      ack = 1'b0; rdata = 8'h00;
      checkOutput("zw_cyc_drop", {31'd0, cyc}, 32'd0);
      checkOutput("zw_txvalid", {31'd0, txValid}, 32'd1);
      expectResponse("zw_status", 8'h06);
      expectResponse("zw_data", 8'h5A);

      // Write to 0xFFFF0000 answered with ERR.
      applyStimulus(8'h57); applyStimulus(8'hFF); applyStimulus(8'hFF);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'hAA);
      checkOutput("we_addr", addr, 32'hFFFF0000);
      @(negedge clock);
      err = 1'b1;
      @(negedge clock);
      err = 1'b0;
      expectResponse("we_resp", 8'h15);
      checkOutput("we_no_more", {31'd0, txValid}, 32'd0);

      // Read answered with ERR together with ACK in the accept cycle: ERR wins, no data byte.
      applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h08);
      err = 1'b1; ack = 1'b1; rdata = 8'h77;
      @(negedge clock);
      err = 1'b0; ack = 1'b0; rdata = 8'h00;
      checkOutput("re_cyc_drop", {31'd0, cyc}, 32'd0);
      expectResponse("re_resp", 8'h15);
      checkOutput("re_no_data", {31'd0, txValid}, 32'd0);
      checkOutput("re_idle_busy", {31'd0, busy}, 32'd0);

      // Timeout: slave never answers, late ACK after abort is ignored.
      applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h40); applyStimulus(8'h11);
      hiCount = 0;
      for (int i = 0; i < 12; i++) begin
         if (cyc) hiCount++;
         if (i == 10) ack = 1'b1;
         if (i == 11) ack = 1'b0;
         @(negedge clock);
      end
      checkOutput("to_cyc_cycles", hiCount, 32'd9);
      expectResponse("to_resp", 8'h54);
      checkOutput("to_no_more", {31'd0, txValid}, 32'd0);
      applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h44); applyStimulus(8'h22);
      checkOutput("to_next_addr", addr, 32'h44);
      checkOutput("to_next_wdata", {24'd0, wdata}, 32'h22);
      @(negedge clock);
      ack = 1'b1;
      @(negedge clock);
      ack = 1'b0;
      expectResponse("to_next_resp", 8'h06);

      // Unknown command with TX back-pressure held for five cycles.
      applyStimulus(8'h41);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_txvalid", {31'd0, txValid}, 32'd1);
         checkOutput("bp_txdata", {24'd0, txData}, 32'h3F);
         checkOutput("bp_rxready", {31'd0, rxReady}, 32'd0);
         @(negedge clock);
      end
      expectResponse("bp_resp", 8'h3F);
      checkOutput("bp_idle_busy", {31'd0, busy}, 32'd0);

      // Reset in the middle of a frame, then one full write.
      applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h00);
      rstn = 1'b0;
      @(negedge clock);
      rstn = 1'b1;
      checkOutput("mr_busy", {31'd0, busy}, 32'd0);
      checkOutput("mr_txvalid", {31'd0, txValid}, 32'd0);
      checkOutput("mr_rxready", {31'd0, rxReady}, 32'd1);
      applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h50); applyStimulus(8'h33);
      checkOutput("mr_stb", {31'd0, stb}, 32'd1);
      checkOutput("mr_addr", addr, 32'h50);
      checkOutput("mr_wdata", {24'd0, wdata}, 32'h33);
      @(negedge clock);
      ack = 1'b1;
      @(negedge clock);
      ack = 1'b0;
      expectResponse("mr_resp", 8'h06);
      hiCount = 0;
      for (int i = 0; i < 4; i++) begin
         if (txValid || cyc) hiCount++;
         @(negedge clock);
      end
      checkOutput("mr_quiet", hiCount, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
